// File: rtl/star_field_gen.sv
// Scrolling pseudo-random starfield generator. The screen is hashed into
// 32x32 cells, each holding at most one star pixel. The field scrolls down
// once every SCROLL_DIV frames, and a subset of the stars twinkle with an LFSR.
module star_field_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned DENSITY    = 8,
  parameter int unsigned SCROLL_DIV = 2,
  parameter int unsigned LEFT_X     = 1,
  parameter int unsigned RIGHT_X    = 635,
  parameter int unsigned TOP_Y      = 32,
  parameter int unsigned BOTTOM_Y   = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        putStar,
  output logic        twinkleOn
);

  localparam int unsigned DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  // Bit i is set when hash nibble value i denotes an occupied cell.
  localparam logic [15:0] EXIST_MASK = 16'((32'd1 << DENSITY) - 32'd1);

  // Frame-rate state
  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      scroll_q, scroll_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_step;
  logic             twinkle_q, twinkle_d;

  // Stage-1 pipeline registers
  logic [10:0] ys_d;
  logic        area_d;
  logic [5:0]  cx_s1_q, cy_s1_q;
  logic [4:0]  xo_s1_q, yo_s1_q;
  logic        area_s1_q, tw_s1_q;

  // Stage-2 hash and result
  logic [15:0] prod, h;
  logic        put_q, put_d;

  // Frame update: scroll divider, Galois LFSR step and twinkle phase.
  always_comb begin
    div_d     = div_q;
    scroll_d  = scroll_q;
    lfsr_d    = lfsr_q;
    twinkle_d = twinkle_q;
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (startOfFrame && enable) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        scroll_d = scroll_q + 11'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
      lfsr_d    = (lfsr_step == '0) ? SEED : lfsr_step;
      twinkle_d = lfsr_d[0];
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      scroll_q  <= '0;
      lfsr_q    <= SEED;
      twinkle_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      scroll_q  <= scroll_d;
      lfsr_q    <= lfsr_d;
      twinkle_q <= twinkle_d;
    end
  end

  // Stage-1 combinational: scrolled row and visible-area test on raw coordinates.
  always_comb begin
    ys_d   = pixelY - scroll_q;
    area_d = ({21'd0, pixelX} > LEFT_X) && ({21'd0, pixelX} < RIGHT_X) &&
             ({21'd0, pixelY} > TOP_Y)  && ({21'd0, pixelY} < BOTTOM_Y) && enable;
  end

  // Stage-1 registers; the twinkle phase travels with the pixel so a pixel
  // sampled together with the frame pulse still sees the old phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_s1_q   <= '0;
      cy_s1_q   <= '0;
      xo_s1_q   <= '0;
      yo_s1_q   <= '0;
      area_s1_q <= 1'b0;
      tw_s1_q   <= 1'b0;
    end else begin
      cx_s1_q   <= pixelX[10:5];
      cy_s1_q   <= ys_d[10:5];
      xo_s1_q   <= pixelX[4:0];
      yo_s1_q   <= ys_d[4:0];
      area_s1_q <= area_d;
      tw_s1_q   <= twinkle_q;
    end
  end

  // Stage-2 combinational: cell hash gives existence, in-cell offset and twinkler flag.
  always_comb begin
    prod  = {4'd0, cy_s1_q, cx_s1_q} * 16'h9E37;
    h     = prod ^ SEED;
    put_d = area_s1_q && EXIST_MASK[h[3:0]] &&
            (xo_s1_q == h[15:11]) && (yo_s1_q == h[10:6]) &&
            ((h[5:4] != 2'b11) || tw_s1_q);
  end

  // Stage-2 output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) put_q <= 1'b0;
    else       put_q <= put_d;
  end

  assign putStar   = put_q;
  assign twinkleOn = twinkle_q;

endmodule

// File: tb/tb_star_field_gen.sv
// Randomized bench for star_field_gen: three instances (default density,
// empty field, full field) share one stimulus stream and are compared every
// cycle against a behavioural model of the starfield.
module tb_star_field_gen;

  localparam int unsigned SEED_V = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, sof, en;
  logic [10:0] px, py;
  logic        put_d8, put_d0, put_d16;
  logic        tw_d8, tw_d0, tw_d16;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model state
  int unsigned m_scroll, m_div, m_lfsr;
  bit          m_tw;
  bit          e_prev [3];
  int unsigned dens   [3] = '{8, 0, 16};

  always #5 clk = ~clk;

  star_field_gen dut_d8 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en),
    .pixelX(px), .pixelY(py), .putStar(put_d8), .twinkleOn(tw_d8)
  );

  star_field_gen #(.DENSITY(0)) dut_d0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en),
    .pixelX(px), .pixelY(py), .putStar(put_d0), .twinkleOn(tw_d0)
  );

  star_field_gen #(.DENSITY(16)) dut_d16 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en),
    .pixelX(px), .pixelY(py), .putStar(put_d16), .twinkleOn(tw_d16)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned cell_hash(input int unsigned cx, input int unsigned cy);
    return ((((cy * 64) + cx) * 40503) % 65536) ^ SEED_V;
  endfunction

  // Star decision straight from the cell rules.
  function automatic bit model_star(input int unsigned x, input int unsigned y,
                                    input int unsigned density, input int unsigned scroll,
                                    input bit tw, input bit e);
    int unsigned ys, h;
    if (!e) return 1'b0;
    if (!(x > 1 && x < 635 && y > 32 && y < 400)) return 1'b0;
    ys = (y + 2048 - scroll) % 2048;
    h  = cell_hash(x / 32, ys / 32);
    if ((h % 16) >= density) return 1'b0;
    if ((x % 32) != (h / 2048)) return 1'b0;
    if ((ys % 32) != ((h / 64) % 32)) return 1'b0;
    if (((h / 16) % 4) == 3 && !tw) return 1'b0;
    return 1'b1;
  endfunction

  // Screen position of the candidate star of cell (cx, cy) at a given scroll.
  task automatic star_xy(input int unsigned cx, input int unsigned cy, input int unsigned scroll,
                         output int unsigned x, output int unsigned y);
    int unsigned h;
    h = cell_hash(cx, cy);
    x = cx * 32 + h / 2048;
    y = (cy * 32 + (h / 64) % 32 + scroll) % 2048;
  endtask

  task automatic model_reset();
    m_scroll = 0;
    m_div    = 0;
    m_lfsr   = SEED_V;
    m_tw     = 1'b1;
    for (int i = 0; i < 3; i++) e_prev[i] = 1'b0;
  endtask

  task automatic model_frame();
    int unsigned nl;
    m_div++;
    if (m_div == 2) begin
      m_div    = 0;
      m_scroll = (m_scroll + 1) % 2048;
    end
    nl = (m_lfsr / 2) ^ ((m_lfsr % 2) ? 32'hB400 : 32'h0);
    if (nl == 0) nl = SEED_V;
    m_lfsr = nl;
    m_tw   = nl[0];
  endtask

  // One clock: present a pixel, then check the result of the pixel from the previous call.
  task automatic step(input int unsigned x, input int unsigned y, input bit s, input bit e);
    bit e_new [3];
    px  = 11'(x);
    py  = 11'(y);
    sof = s;
    en  = e;
    for (int i = 0; i < 3; i++) e_new[i] = model_star(x, y, dens[i], m_scroll, m_tw, e);
    @(posedge clk);
    if (s && e) model_frame();
    #1;
    check_eq("put_d8",  put_d8,  e_prev[0]);
    check_eq("put_d0",  put_d0,  e_prev[1]);
    check_eq("put_d16", put_d16, e_prev[2]);
    check_eq("tw_d8",   tw_d8,   m_tw);
    check_eq("tw_d16",  tw_d16,  m_tw);
    for (int i = 0; i < 3; i++) e_prev[i] = e_new[i];
  endtask

  task automatic do_reset();
    sof = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_put_d8",  put_d8,  0);
    check_eq("rst_put_d16", put_d16, 0);
    check_eq("rst_tw",      tw_d8,   1);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_target(output int unsigned x, output int unsigned y);
    int unsigned r;
    star_xy($urandom_range(0, 19), $urandom_range(0, 63), m_scroll, x, y);
    if (y >= 480) y = $urandom_range(0, 479);
    r = $urandom_range(0, 9);
    case (r)
      0: x = (x + 1) % 2048;
      1: x = (x + 2047) % 2048;
      2: y = (y + 1) % 2048;
      3: x = ($urandom_range(0, 1) != 0) ? 1 : 635;
      4: y = ($urandom_range(0, 1) != 0) ? 32 : 400;
      default: ;
    endcase
  endtask

  task automatic target_sweep(input bit e);
    int unsigned x, y;
    for (int cx = 0; cx < 20; cx++)
      for (int cy = 0; cy < 64; cy++) begin
        star_xy(cx, cy, m_scroll, x, y);
        if (y < 480) begin
          step(x, y, 1'b0, e);
          step(x, y + 1, 1'b0, e);
        end
      end
  endtask

  task automatic border_sweep(input bit e);
    for (int y = 0; y < 480; y++) begin
      step(1, y, 1'b0, e);
      step(635, y, 1'b0, e);
      step(2, y, 1'b0, e);
      step(634, y, 1'b0, e);
    end
    for (int x = 0; x < 640; x++) begin
      step(x, 32, 1'b0, e);
      step(x, 400, 1'b0, e);
      step(x, 33, 1'b0, e);
      step(x, 399, 1'b0, e);
    end
  endtask

  initial begin
    int unsigned x, y;
    bit s, e;
    reset = 1'b0; sof = 1'b0; en = 1'b1; px = '0; py = '0;
    #1;
    do_reset();

    // Reset state: star of cell (0,0) sits at y=19, above the top border.
    step(21, 19, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    check_eq("p21_19_scroll0", put_d8, 0);
    check_eq("tw_after_reset", tw_d8, 1);
    target_sweep(1'b1);

    // LFSR sequence E270, 7138, 389C: twinkle phase low on the first three pulses.
    for (int i = 0; i < 28; i++) begin
      rand_target(x, y);
      step(x, y, 1'b1, 1'b1);
      if (i < 3) check_eq("tw_pulse", tw_d8, 0);
    end

    // scrollY = 14: cell (0,0) star now at (21,33).
    step(21, 33, 1'b0, 1'b1);
    step(20, 33, 1'b0, 1'b1);
    check_eq("star_21_33", put_d8, 1);
    step(22, 33, 1'b0, 1'b1);
    check_eq("p20_33", put_d8, 0);
    step(21, 34, 1'b0, 1'b1);
    check_eq("p22_33", put_d8, 0);
    step(0, 0, 1'b0, 1'b1);
    check_eq("p21_34", put_d8, 0);
    target_sweep(1'b1);
    border_sweep(1'b1);

    // Full scroll wrap: 4096 pulses bring scrollY back to 0.
    do_reset();
    for (int i = 0; i < 8192; i++) begin
      rand_target(x, y);
      step(x, y, (i % 2) == 0, 1'b1);
    end
    step(21, 19, 1'b0, 1'b1);
    step(21, 33, 1'b0, 1'b1);
    check_eq("wrap_p21_19", put_d8, 0);
    step(0, 0, 1'b0, 1'b1);
    check_eq("wrap_p21_33", put_d8, 0);

    // Disabled: pulses ignored, no stars anywhere.
    for (int i = 0; i < 10; i++) begin
      rand_target(x, y);
      step(x, y, 1'b1, 1'b0);
    end
    target_sweep(1'b0);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1'b0);
    target_sweep(1'b1);

    // Random frame pulses, enable toggling, and a reset in mid-stream.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_target(x, y);
      s = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 7) != 0);
      step(x, y, s, e);
    end
    border_sweep(1'b1);
    step(0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
